intersection_phase_scheduler: RTL and testbench

//  Sequences a two-road intersection (main/auxiliary) through green/yellow/all-red phases.

---
 rtl/intersection_phase_scheduler.sv | 138 +++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase sequencer with pedestrian walk phase and emergency preemption.
// Phase timing advances on the external tick strobe; all outputs are registered.
module intersection_phase_scheduler #(
    parameter int MAIN_GREEN = 15,
    parameter int AUX_GREEN  = 7,
    parameter int YELLOW     = 3,
    parameter int ALL_RED    = 1,
    parameter int PED_WALK   = 6,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             RST_n,
    input  logic             tick,
    input  logic             ped_req,
    output logic             ped_ack,
    input  logic             emg_req,
    input  logic             emg_dir,
    output logic             emg_active,
    output logic [2:0]       light_main,
    output logic [2:0]       light_aux,
    output logic             walk,
    output logic [CNT_W-1:0] phase_cnt
);

    // state  | meaning
    // MAIN_G | main green, aux red
    // MAIN_Y | main yellow, aux red
    // ALL_R1 | clearance before aux green
    // AUX_G  | aux green, main red
    // AUX_Y  | aux yellow, main red
    // ALL_R2 | clearance before main green or walk
    // PED    | both red, walk lamp on
    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        ALL_R1 = 3'd2,
        AUX_G  = 3'd3,
        AUX_Y  = 3'd4,
        ALL_R2 = 3'd5,
        PED    = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    state_t           state, state_nxt, seq_nxt, emg_green, emg_other;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pend_nxt, ped_pending;
    logic             hold, phase_end, legal;

    function automatic logic [CNT_W-1:0] dur(input state_t s);
        case (s)
            MAIN_G:          dur = CNT_W'(MAIN_GREEN);
            AUX_G:           dur = CNT_W'(AUX_GREEN);
            MAIN_Y, AUX_Y:   dur = CNT_W'(YELLOW);
            ALL_R1, ALL_R2:  dur = CNT_W'(ALL_RED);
            PED:             dur = CNT_W'(PED_WALK);
            default:         dur = CNT_W'(MAIN_GREEN);
        endcase
    endfunction

    function automatic logic [2:0] lamp_main(input state_t s);
        case (s)
            MAIN_G:  lamp_main = LAMP_G;
            MAIN_Y:  lamp_main = LAMP_Y;
            default: lamp_main = LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] lamp_aux(input state_t s);
        case (s)
            AUX_G:   lamp_aux = LAMP_G;
            AUX_Y:   lamp_aux = LAMP_Y;
            default: lamp_aux = LAMP_R;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = phase_cnt;
        pend_nxt  = ped_pending | ped_req;
        emg_green = emg_dir ? AUX_G : MAIN_G;
        emg_other = emg_dir ? MAIN_G : AUX_G;
        legal     = (state <= PED);
        // While the preempted road is green the counter is frozen.
        hold      = emg_req && (state == emg_green);
        phase_end = tick && !hold &&
                    ((phase_cnt == CNT_W'(1)) ||
                     (emg_req && ((state == emg_other) || (state == PED))));

        case (state)
            MAIN_G:  seq_nxt = MAIN_Y;
            MAIN_Y:  seq_nxt = ALL_R1;
            ALL_R1:  seq_nxt = emg_req ? emg_green : AUX_G;
            AUX_G:   seq_nxt = AUX_Y;
            AUX_Y:   seq_nxt = ALL_R2;
            ALL_R2:  seq_nxt = emg_req ? emg_green : (pend_nxt ? PED : MAIN_G);
            PED:     seq_nxt = emg_req ? emg_green : MAIN_G;
            default: seq_nxt = MAIN_G;
        endcase

        if (!legal) begin
            state_nxt = MAIN_G;
            cnt_nxt   = dur(MAIN_G);
        end else if (phase_end) begin
            state_nxt = seq_nxt;
            cnt_nxt   = dur(seq_nxt);
            if (seq_nxt == PED)
                pend_nxt = 1'b0;
        end else if (tick && !hold) begin
            cnt_nxt = phase_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state       <= MAIN_G;
            phase_cnt   <= CNT_W'(MAIN_GREEN);
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
            emg_active  <= 1'b0;
            light_main  <= LAMP_G;
            light_aux   <= LAMP_R;
            walk        <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase_cnt   <= cnt_nxt;
            ped_pending <= pend_nxt;
            ped_ack     <= ped_req & ~ped_pending;
            emg_active  <= emg_req && (state_nxt == emg_green);
            light_main  <= lamp_main(state_nxt);
            light_aux   <= lamp_aux(state_nxt);
            walk        <= (state_nxt == PED);
        end
    end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: phase-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       RST_n, tick, ped_req, emg_req, emg_dir;
    logic       ped_ack, emg_active, walk;
    logic [2:0] light_main, light_aux;
    logic [4:0] phase_cnt;

    int errors = 0;
    int checks = 0;

    // Phase index: 0 main green, 1 main yellow, 2 all-red, 3 aux green, 4 aux yellow, 5 all-red, 6 walk
    int dur [7] = '{15, 3, 1, 7, 3, 1, 6};
    int lm  [7] = '{4, 2, 1, 1, 1, 1, 1};
    int la  [7] = '{1, 1, 1, 4, 2, 1, 1};
    int m_ph, m_rem;
    bit m_pend, m_ack, m_emg;

    intersection_phase_scheduler dut (
        .clk(clk), .RST_n(RST_n), .tick(tick), .ped_req(ped_req), .ped_ack(ped_ack),
        .emg_req(emg_req), .emg_dir(emg_dir), .emg_active(emg_active),
        .light_main(light_main), .light_aux(light_aux), .walk(walk), .phase_cnt(phase_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ph = 0; m_rem = dur[0]; m_pend = 0; m_ack = 0; m_emg = 0;
    endtask

    task automatic m_step();
        int d, opp, np;
        bit pend_n;
        d      = emg_dir ? 3 : 0;
        opp    = emg_dir ? 0 : 3;
        m_ack  = ped_req && !m_pend;
        pend_n = m_pend || ped_req;
        if (tick && !(emg_req && m_ph == d)) begin
            if (m_rem == 1 || (emg_req && (m_ph == opp || m_ph == 6))) begin
                if (m_ph == 0 || m_ph == 1 || m_ph == 3 || m_ph == 4) np = m_ph + 1;
                else if (emg_req)                                     np = d;
                else if (m_ph == 2)                                   np = 3;
                else if (m_ph == 5 && pend_n)                         np = 6;
                else                                                  np = 0;
                if (np == 6) pend_n = 0;
                m_ph  = np;
                m_rem = dur[np];
            end else begin
                m_rem--;
            end
        end
        m_pend = pend_n;
        m_emg  = emg_req && (m_ph == d);
    endtask

    function automatic int m_vec();
        return (lm[m_ph] << 11) | (la[m_ph] << 8) | (int'(m_ph == 6) << 7) |
               (int'(m_ack) << 6) | (int'(m_emg) << 5) | m_rem;
    endfunction

    always @(posedge clk) begin
        #1;
        if (!RST_n) m_reset();
        else        m_step();
        chk("cycle", int'({light_main, light_aux, walk, ped_ack, emg_active, phase_cnt}), m_vec());
    end

    task automatic run_ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic ped_pulse();
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_n = 1'b0; tick = 1'b0; ped_req = 1'b0; emg_req = 1'b0; emg_dir = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_main", int'(light_main), 4);
        chk("rst_aux", int'(light_aux), 1);
        chk("rst_cnt", int'(phase_cnt), 15);
        chk("rst_walk", int'(walk), 0);
        RST_n = 1'b1;

        // Normal cycle
        run_ticks(15);
        chk("t1_main_y", int'(light_main), 2);
        chk("t1_y_cnt", int'(phase_cnt), 3);
        run_ticks(15);
        chk("t1_wrap_main", int'(light_main), 4);
        chk("t1_wrap_cnt", int'(phase_cnt), 15);
        run_ticks(30);
        chk("t1_wrap2_cnt", int'(phase_cnt), 15);

        // Pedestrian request served after ALL_R2
        run_ticks(3);
        chk("t2_cnt12", int'(phase_cnt), 12);
        ped_pulse();
        chk("t2_ack", int'(ped_ack), 1);
        @(negedge clk);
        chk("t2_ack_low", int'(ped_ack), 0);
        ped_pulse();
        chk("t2_no_reack", int'(ped_ack), 0);
        run_ticks(27);
        chk("t2_walk", int'(walk), 1);
        chk("t2_ped_main", int'(light_main), 1);
        chk("t2_ped_aux", int'(light_aux), 1);
        chk("t2_ped_cnt", int'(phase_cnt), 6);
        run_ticks(6);
        chk("t2_walk_off", int'(walk), 0);
        chk("t2_back_main", int'(light_main), 4);
        chk("t2_back_cnt", int'(phase_cnt), 15);
        run_ticks(30);
        chk("t2_no_ped_main", int'(light_main), 4);
        chk("t2_no_ped_cnt", int'(phase_cnt), 15);

        // Emergency toward aux while main is green
        run_ticks(5);
        chk("t3_cnt10", int'(phase_cnt), 10);
        emg_dir = 1'b1; emg_req = 1'b1;
        run_ticks(1);
        chk("t3_main_y", int'(light_main), 2);
        chk("t3_y_cnt", int'(phase_cnt), 3);
        run_ticks(4);
        chk("t3_aux_g", int'(light_aux), 4);
        chk("t3_aux_cnt", int'(phase_cnt), 7);
        chk("t3_emg_on", int'(emg_active), 1);
        run_ticks(20);
        chk("t3_frozen", int'(phase_cnt), 7);
        chk("t3_emg_held", int'(emg_active), 1);
        emg_req = 1'b0;
        run_ticks(6);
        chk("t3_cnt1", int'(phase_cnt), 1);
        chk("t3_still_g", int'(light_aux), 4);
        run_ticks(1);
        chk("t3_aux_y", int'(light_aux), 2);
        run_ticks(4);
        chk("t3_main_back", int'(light_main), 4);

        // Emergency toward main while main is green
        run_ticks(6);
        chk("t4_cnt9", int'(phase_cnt), 9);
        emg_dir = 1'b0; emg_req = 1'b1;
        run_ticks(10);
        chk("t4_frozen", int'(phase_cnt), 9);
        chk("t4_main_g", int'(light_main), 4);
        chk("t4_emg_on", int'(emg_active), 1);
        emg_req = 1'b0;
        run_ticks(8);
        chk("t4_cnt1", int'(phase_cnt), 1);
        run_ticks(1);
        chk("t4_main_y", int'(light_main), 2);

        // Emergency during walk phase
        ped_pulse();
        chk("t5_ack", int'(ped_ack), 1);
        run_ticks(15);
        chk("t5_walk", int'(walk), 1);
        run_ticks(2);
        chk("t5_ped_cnt", int'(phase_cnt), 4);
        emg_dir = 1'b1; emg_req = 1'b1;
        run_ticks(1);
        chk("t5_aux_g", int'(light_aux), 4);
        chk("t5_walk_off", int'(walk), 0);
        chk("t5_cnt7", int'(phase_cnt), 7);
        chk("t5_emg_on", int'(emg_active), 1);
        emg_req = 1'b0;
        run_ticks(11);
        chk("t5_no_ped_main", int'(light_main), 4);
        chk("t5_no_ped_walk", int'(walk), 0);
        chk("t5_no_ped_cnt", int'(phase_cnt), 15);

        // Asynchronous reset in the middle of AUX_Y
        emg_dir = 1'b0;
        run_ticks(26);
        chk("t6_aux_y", int'(light_aux), 2);
        run_ticks(1);
        chk("t6_cnt2", int'(phase_cnt), 2);
        #2;
        RST_n = 1'b0;
        #1;
        chk("t6_rst_main", int'(light_main), 4);
        chk("t6_rst_aux", int'(light_aux), 1);
        chk("t6_rst_cnt", int'(phase_cnt), 15);
        chk("t6_rst_flags", int'({walk, ped_ack, emg_active}), 0);
        repeat (2) @(negedge clk);
        RST_n = 1'b1;
        run_ticks(14);
        chk("t6_cnt1", int'(phase_cnt), 1);
        chk("t6_main_g", int'(light_main), 4);
        run_ticks(1);
        chk("t6_main_y", int'(light_main), 2);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
